aqfp_bist_ctrl: RTL and testbench

- Sequential stimulus/response controller for the combinational AQFP benchmark netlists (26-in / 10-out class).
- Drives pseudo-random input vectors into the netlist under test and compacts the returned outputs into a signature.
- Delay-tracks the netlist pipeline depth so AQFP-balanced (clocked) versions can be checked against golden signatures on-chip or in simulation.

---
 rtl/aqfp_bist_pkg.sv | 23 ++
 rtl/aqfp_misr.sv | 43 ++++
 rtl/aqfp_bist_ctrl.sv | 149 ++++++++++++++
 tb/tb_aqfp_bist_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aqfp_bist_pkg.sv
// Shared definitions for the AQFP benchmark BIST harness: FSM states,
// polynomial tap masks and default seeds.
package aqfp_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // x^26+x^6+x^2+x+1 -> feedback from bits 25,5,1,0
    localparam logic [25:0] LFSR26_TAPS = 26'h2000023;
    // feedback from bits 15,13,12,10
    localparam logic [15:0] MISR16_TAPS = 16'hB400;

    localparam logic [25:0] LFSR26_SEED = 26'h0000001;
    localparam logic [15:0] MISR16_SEED = 16'h0000;

    // Largest legal pattern count: one less than the LFSR period.
    localparam int unsigned LFSR26_MAX_PATTERNS = 32'd67108862;

endpackage

// File: rtl/aqfp_misr.sv
// Multiple-input signature register: shift with tap-mask feedback, then XOR in
// the zero-extended response word. Reusable by other benchmark harnesses.
module aqfp_misr
    import aqfp_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter int unsigned      DIN_W = 10,
    parameter logic [SIG_W-1:0] TAPS  = MISR16_TAPS,
    parameter logic [SIG_W-1:0] SEED  = MISR16_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    logic [SIG_W-1:0] din_ext;
    logic             fb;

    assign din_ext = SIG_W'(din);
    assign fb      = ^(sig & TAPS);

    always_comb begin
        sig_next = sig;
        if (clear) begin
            sig_next = SEED;
        end else if (en) begin
            sig_next = {sig[SIG_W-2:0], fb} ^ din_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/aqfp_bist_ctrl.sv
// Stimulus/response BIST controller for combinational or clock-balanced AQFP
// netlists: LFSR patterns out, latency-aligned MISR compaction of responses in.
module aqfp_bist_ctrl
    import aqfp_bist_pkg::*;
#(
    parameter int unsigned      IN_W         = 26,
    parameter int unsigned      OUT_W        = 10,
    parameter int unsigned      SIG_W        = 16,
    parameter int unsigned      NUM_PATTERNS = 1024,
    parameter int unsigned      DUT_LATENCY  = 0,
    parameter logic [IN_W-1:0]  LFSR_SEED    = LFSR26_SEED,
    parameter logic [SIG_W-1:0] MISR_SEED    = MISR16_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  pattern_o,
    output logic             pattern_valid_o,
    input  logic [OUT_W-1:0] response_i,
    input  logic [SIG_W-1:0] golden_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature_o
);

    localparam int unsigned CNT_W      = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned DRN_W      = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;
    localparam int unsigned DRAIN_LAST = (DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0;
    localparam logic [IN_W-1:0] LFSR_TAPS = IN_W'(LFSR26_TAPS);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > LFSR26_MAX_PATTERNS) begin : g_bad_patterns
        $error("aqfp_bist_ctrl: NUM_PATTERNS out of range");
    end
    if (OUT_W > SIG_W) begin : g_bad_out_w
        $error("aqfp_bist_ctrl: OUT_W must not exceed SIG_W");
    end

    bist_state_t      state, state_next;
    logic [IN_W-1:0]  lfsr;
    logic [CNT_W-1:0] pat_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             load;
    logic             flush;
    logic             last_pat;
    logic             drain_last;
    logic             cap_en;
    logic [SIG_W-1:0] sig_next;

    assign last_pat   = (pat_cnt == CNT_W'(NUM_PATTERNS - 1));
    assign drain_last = (drn_cnt == DRN_W'(DRAIN_LAST));
    assign flush      = load | abort;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_pat) begin
                    state_next = (DUT_LATENCY > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            load       = 1'b0;
        end
    end

    // The final RUN edge does not advance the LFSR, so DRAIN keeps showing the last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lfsr    <= LFSR_SEED;
            pat_cnt <= '0;
            drn_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state <= state_next;
            pass  <= (state_next == ST_DONE) && (sig_next == golden_i);
            if (load) begin
                lfsr    <= LFSR_SEED;
                pat_cnt <= '0;
            end else if (state == ST_RUN) begin
                pat_cnt <= pat_cnt + CNT_W'(1);
                if (!last_pat) begin
                    lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
                end
            end
            if (state == ST_DRAIN) begin
                drn_cnt <= drn_cnt + DRN_W'(1);
            end else begin
                drn_cnt <= '0;
            end
        end
    end

    if (DUT_LATENCY == 0) begin : g_no_delay
        assign cap_en = pattern_valid_o;
    end else begin : g_delay
        logic [DUT_LATENCY-1:0] dly;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly <= '0;
            end else if (flush) begin
                dly <= '0;
            end else begin
                dly <= (dly << 1) | DUT_LATENCY'(pattern_valid_o);
            end
        end

        assign cap_en = dly[DUT_LATENCY-1];
    end

    aqfp_misr #(
        .SIG_W (SIG_W),
        .DIN_W (OUT_W),
        .TAPS  (SIG_W'(MISR16_TAPS)),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (load),
        .en       (cap_en),
        .din      (response_i),
        .sig      (signature_o),
        .sig_next (sig_next)
    );

    assign pattern_o       = lfsr;
    assign pattern_valid_o = (state == ST_RUN);
    assign busy            = (state == ST_RUN) || (state == ST_DRAIN);
    assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_aqfp_bist_ctrl.sv
// Scoreboard bench for aqfp_bist_ctrl: five instances with different pattern
// counts and latencies, expected results queued at stimulus time.
module tb_aqfp_bist_ctrl;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        bit          sig_care;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st   [5];
    logic        ab   [5];
    logic [25:0] pat  [5];
    logic        pv   [5];
    logic [15:0] gold [5];
    logic        busy [5];
    logic        done [5];
    logic        pass [5];
    logic [15:0] sig  [5];

    logic [9:0]  d_r1, d_r2, e_r1, e_r2;

    int checks = 0;
    int errors = 0;
    int a_pv_cnt = 0;
    int busy_cnt [5] = '{0, 0, 0, 0, 0};
    logic done_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [25:0] a_pat_q [$];
    res_t        res_q   [5][$];

    always #5 clk = ~clk;

    // Instances: A N=4 L=0, B N=2 L=0, C N=1024 L=3, D N=16 L=2, E N=16 L=1
    aqfp_bist_ctrl #(.NUM_PATTERNS(4), .DUT_LATENCY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
        .pattern_o(pat[0]), .pattern_valid_o(pv[0]), .response_i(10'h000),
        .golden_i(gold[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .signature_o(sig[0]));
    aqfp_bist_ctrl #(.NUM_PATTERNS(2), .DUT_LATENCY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
        .pattern_o(pat[1]), .pattern_valid_o(pv[1]), .response_i(10'h001),
        .golden_i(gold[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .signature_o(sig[1]));
    aqfp_bist_ctrl #(.NUM_PATTERNS(1024), .DUT_LATENCY(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]),
        .pattern_o(pat[2]), .pattern_valid_o(pv[2]), .response_i(10'h000),
        .golden_i(gold[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .signature_o(sig[2]));
    aqfp_bist_ctrl #(.NUM_PATTERNS(16), .DUT_LATENCY(2)) u_d (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .abort(ab[3]),
        .pattern_o(pat[3]), .pattern_valid_o(pv[3]), .response_i(d_r2),
        .golden_i(gold[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .signature_o(sig[3]));
    aqfp_bist_ctrl #(.NUM_PATTERNS(16), .DUT_LATENCY(1)) u_e (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .abort(ab[4]),
        .pattern_o(pat[4]), .pattern_valid_o(pv[4]), .response_i(e_r2),
        .golden_i(gold[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]),
        .signature_o(sig[4]));

    // Two-stage netlist model: response equals the pattern two cycles earlier.
    always @(posedge clk) begin
        d_r1 <= pat[3][9:0];
        d_r2 <= d_r1;
        e_r1 <= pat[4][9:0];
        e_r2 <= e_r1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] lfsr_step(input logic [25:0] v);
        logic fb;
        fb = v[25] ^ v[5] ^ v[1] ^ v[0];
        return {v[24:0], fb};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [9:0] d);
        logic fb;
        fb = m[15] ^ m[13] ^ m[12] ^ m[10];
        return {m[14:0], fb} ^ {6'b0, d};
    endfunction

    // Monitor: pattern stream of A, and result at every rising done of each instance.
    always @(negedge clk) begin
        res_t r;
        if (pv[0]) begin
            a_pv_cnt++;
            if (a_pat_q.size() == 0) chk("a_pattern_extra", 32'(pv[0]), 32'd0);
            else chk("a_pattern", 32'(pat[0]), 32'(a_pat_q.pop_front()));
        end
        for (int i = 0; i < 5; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (done[i] && !done_d[i]) begin
                if (res_q[i].size() == 0) begin
                    chk($sformatf("done%0d_unexpected", i), 32'(done[i]), 32'd0);
                end else begin
                    r = res_q[i].pop_front();
                    if (r.sig_care) chk($sformatf("sig%0d", i), 32'(sig[i]), 32'(r.sig));
                    chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(r.pass));
                end
            end
            done_d[i] = done[i];
        end
    end

    task automatic wait_done(input int idx, input int limit, output int edges);
        edges = 0;
        while (!done[idx] && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk($sformatf("done%0d_reached", idx), 32'(done[idx]), 32'd1);
    endtask

    initial begin
        int          e;
        int          b0;
        logic [25:0] p;
        logic [15:0] model;
        logic [25:0] p1024;

        for (int i = 0; i < 5; i++) begin
            st[i]   = 1'b0;
            ab[i]   = 1'b0;
            gold[i] = 16'h0000;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_pass", 32'(pass[0]), 32'd0);
        chk("rst_valid", 32'(pv[0]), 32'd0);
        chk("rst_pattern", 32'(pat[0]), 32'h0000001);
        chk("rst_sig", 32'(sig[0]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A: seed sequence, start during RUN ignored
        a_pat_q.push_back(26'h0000001);
        a_pat_q.push_back(26'h0000003);
        a_pat_q.push_back(26'h0000006);
        a_pat_q.push_back(26'h000000D);
        res_q[0].push_back('{16'h0000, 1'b1, 1'b1});
        st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        @(posedge clk); #1; st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        wait_done(0, 20, e);
        chk("a_done_edge", 32'(e), 32'd2);
        chk("a_valid_cycles", 32'(a_pv_cnt), 32'd4);

        // B: MISR arithmetic with constant response 1
        gold[1] = 16'h0003;
        res_q[1].push_back('{16'h0003, 1'b1, 1'b1});
        st[1] = 1'b1;
        @(posedge clk); #1; st[1] = 1'b0;
        wait_done(1, 10, e);
        chk("b_done_edge", 32'(e), 32'd2);
        gold[1] = 16'h0004;
        @(posedge clk); #1;
        chk("b_pass_wrong_golden", 32'(pass[1]), 32'd0);
        chk("b_sig_hold", 32'(sig[1]), 32'h0003);
        ab[1] = 1'b1;
        @(posedge clk); #1; ab[1] = 1'b0;
        chk("b_abort_done", 32'(done[1]), 32'd0);

        // C: zero response, long run with latency 3
        res_q[2].push_back('{16'h0000, 1'b1, 1'b1});
        b0 = busy_cnt[2];
        st[2] = 1'b1;
        @(posedge clk); #1; st[2] = 1'b0;
        wait_done(2, 1100, e);
        chk("c_done_edge", 32'(e), 32'd1027);
        chk("c_busy_cycles", 32'(busy_cnt[2] - b0), 32'd1027);

        // D/E: latency alignment against software model
        p = 26'h0000001;
        model = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            model = misr_step(model, p[9:0]);
            p = lfsr_step(p);
        end
        gold[3] = model;
        gold[4] = model;
        res_q[3].push_back('{model, 1'b1, 1'b1});
        res_q[4].push_back('{16'h0000, 1'b0, 1'b0});
        st[3] = 1'b1;
        st[4] = 1'b1;
        @(posedge clk); #1;
        st[3] = 1'b0;
        st[4] = 1'b0;
        wait_done(3, 40, e);
        chk("d_done_edge", 32'(e), 32'd18);
        wait_done(4, 40, e);

        // C: abort in RUN cycle 5, start+abort, restart, reset in DRAIN
        st[2] = 1'b1;
        @(posedge clk); #1; st[2] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        ab[2] = 1'b1;
        @(posedge clk); #1; ab[2] = 1'b0;
        chk("c_abort_busy", 32'(busy[2]), 32'd0);
        chk("c_abort_done", 32'(done[2]), 32'd0);
        chk("c_abort_valid", 32'(pv[2]), 32'd0);
        st[2] = 1'b1;
        ab[2] = 1'b1;
        @(posedge clk); #1;
        st[2] = 1'b0;
        ab[2] = 1'b0;
        chk("c_start_abort_busy", 32'(busy[2]), 32'd0);
        st[2] = 1'b1;
        @(posedge clk); #1; st[2] = 1'b0;
        chk("c_restart_pattern", 32'(pat[2]), 32'h0000001);
        chk("c_restart_valid", 32'(pv[2]), 32'd1);
        p1024 = 26'h0000001;
        for (int k = 1; k < 1024; k++) p1024 = lfsr_step(p1024);
        repeat (1025) begin @(posedge clk); #1; end
        chk("c_drain_busy", 32'(busy[2]), 32'd1);
        chk("c_drain_valid", 32'(pv[2]), 32'd0);
        chk("c_drain_pattern_hold", 32'(pat[2]), 32'(p1024));
        rst_n = 1'b0;
        #1;
        chk("c_rst_busy", 32'(busy[2]), 32'd0);
        chk("c_rst_done", 32'(done[2]), 32'd0);
        chk("c_rst_pass", 32'(pass[2]), 32'd0);
        chk("c_rst_valid", 32'(pv[2]), 32'd0);
        chk("c_rst_pattern", 32'(pat[2]), 32'h0000001);
        chk("c_rst_sig", 32'(sig[2]), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("a_pattern_queue_left", 32'(a_pat_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("result%0d_queue_left", i), 32'(res_q[i].size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
